rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 53 +++++
 tb/tb_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational (zero-cycle) grant from a rotating priority pointer.
// The pointer advances past the most recently granted client so every holder is served in turn.
module rr_arbiter #(
  parameter int CLIENTS = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] request,
  input  logic               stall,
  output logic [CLIENTS-1:0] grant
);

  localparam int PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_valid;
  logic [PW:0]   idx;

  // Scan ptr, ptr+1, ... modulo CLIENTS; one extra bit in idx keeps the sum from overflowing.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(CLIENTS)) begin
        idx = idx - (PW+1)'(CLIENTS);
      end
      if (!grant_valid && request[idx[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (reset && !stall && grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Reset and stall gate the pointer exactly as they gate the grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (!stall && grant_valid) begin
      ptr <= (grant_idx == PW'(CLIENTS - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (CLIENTS=32): vector table, directed corner sequences and a
// random run scored against an independent rotate-and-find-first model.
module tb_rr_arbiter;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         stall;
  logic [N-1:0] grant;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] exp_q[$];
  string        name_q[$];
  logic [4:0]   model_ptr = '0;

  typedef struct {
    logic         rst;
    logic         stl;
    logic [N-1:0] req;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  rr_arbiter #(.CLIENTS(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .request(request),
    .stall  (stall),
    .grant  (grant)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] q, input logic [4:0] p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   g;
    logic           found;
    dbl   = {q, q} >> p;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        g = 32'b1 << ((int'(p) + k) % N);
      end
    end
    return g;
  endfunction

  function automatic logic [4:0] next_ptr(input logic r, input logic [N-1:0] g, input logic [4:0] p);
    logic [4:0] np;
    np = p;
    if (!r) np = '0;
    else begin
      for (int k = 0; k < N; k++) begin
        if (g[k]) np = 5'((k + 1) % N);
      end
    end
    return np;
  endfunction

  task automatic apply_stimulus(input logic r, input logic s, input logic [N-1:0] q,
                                input logic [N-1:0] e, input string nm);
    reset   = r;
    stall   = s;
    request = q;
    exp_q.push_back(e);
    name_q.push_back(nm);
    model_ptr = next_ptr(r, e, model_ptr);
    @(negedge clock);
  endtask

  task automatic check_output();
    logic [N-1:0] e;
    string        nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    tests++;
    if (grant !== e) begin
      fails++;
      $display("[TB] FAIL %s: grant=%h expected=%h", nm, grant, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input logic r, input logic s, input logic [N-1:0] q,
                         input logic [N-1:0] e, input string nm);
    apply_stimulus(r, s, q, e, nm);
    check_output();
    tick();
  endtask

  initial begin
    int           first4;
    int           waits[N];
    logic [N-1:0] held;
    logic [N-1:0] e;
    logic         s;

    reset = 1'b0; stall = 1'b0; request = '0;

    vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0021, 32'h0000_0020};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0021, 32'h0000_0001};
    vecs[6]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0001};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0002};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0201, 32'h0000_0001};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0201, 32'h0000_0200};

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i].rst, vecs[i].stl, vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // All-ones held from ptr=0: grant walks every index and wraps back to 0.
    run_vec(1'b0, 1'b0, '1, '0, "walk_reset");
    for (int k = 0; k <= N; k++) begin
      run_vec(1'b1, 1'b0, '1, 32'b1 << (k % N), $sformatf("walk%0d", k));
    end

    // From ptr=5 client 4 is last in line and must wait the full 31 cycles.
    run_vec(1'b0, 1'b0, '0, '0, "fair_reset");
    run_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, "fair_setup");
    first4 = -1;
    for (int k = 0; k < N; k++) begin
      apply_stimulus(1'b1, 1'b0, '1, 32'b1 << ((5 + k) % N), $sformatf("fair%0d", k));
      check_output();
      if (grant[4] && first4 < 0) first4 = k;
      tick();
    end
    tests++;
    if (first4 != 31) begin
      fails++;
      $display("[TB] FAIL fair_client4: first grant cycle=%0d expected=31", first4);
    end

    // Stall for three cycles at ptr=9, then resume at the same pointer.
    run_vec(1'b0, 1'b0, '0, '0, "stall_reset");
    run_vec(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100, "stall_setup");
    for (int k = 0; k < 3; k++) begin
      run_vec(1'b1, 1'b1, '1, '0, $sformatf("stall%0d", k));
    end
    run_vec(1'b1, 1'b0, '1, 32'h0000_0200, "stall_resume");

    // Random held requests with occasional stalls, scored against the model.
    run_vec(1'b0, 1'b0, '0, '0, "rand_reset");
    held = '0;
    for (int c = 0; c < N; c++) waits[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      held = held | ($urandom() & $urandom() & $urandom());
      s = ($urandom_range(0, 7) == 0);
      e = s ? '0 : model_grant(held, model_ptr);
      apply_stimulus(1'b1, s, held, e, "rand");
      check_output();
      tests++;
      if (($countones(grant) > 1) || ((grant & ~held) != '0)) begin
        fails++;
        $display("[TB] FAIL rand_onehot_subset: grant=%h request=%h", grant, held);
      end
      for (int c = 0; c < N; c++) begin
        if (grant[c]) waits[c] = 0;
        else if (held[c] && !s) waits[c]++;
      end
      tests++;
      for (int c = 0; c < N; c++) begin
        if (waits[c] > N - 1) begin
          fails++;
          $display("[TB] FAIL rand_fairness: client=%0d waited=%0d limit=%0d", c, waits[c], N - 1);
          waits[c] = 0;
          break;
        end
      end
      held = held & ~grant;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
